// File: rtl/hilbert_pkg.sv
// +----------------------------------------------------------------------------+
// | Module : hilbert_pkg                                                       |
// | Shared types, geometry helpers and reference coefficients for the         |
// | time-multiplexed Hilbert FIR.                                              |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

package hilbert_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    localparam int REF_TAPS   = 11;
    localparam int REF_COEF_W = 12;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    function automatic int hilbert_centre(input int taps);
        return (taps - 1) / 2;
    endfunction

    function automatic int hilbert_pairs(input int taps);
        return (hilbert_centre(taps) + 1) / 2;
    endfunction

    localparam int C = hilbert_centre(REF_TAPS);
    localparam int P = hilbert_pairs(REF_TAPS);

    // H(1), H(3), H(5) for the 11-tap, Q1.11 reference filter
    localparam logic signed [REF_COEF_W-1:0] REF_COEF [P] = '{12'sd1304, 12'sd435, 12'sd261};

    // Ideal Hilbert tap 2/(pi*k) in Q1.(coef_w-1), rounded to nearest
    function automatic int hilbert_coef(input int k, input int coef_w);
        longint num;
        longint den;
        num = (longint'(1) << coef_w) * 64'sd2000000;
        den = 64'sd6283186 * longint'(k);
        return int'((num + den / 2) / den);
    endfunction

endpackage

`default_nettype wire

// File: rtl/hilbert_coef_rom.sv
// +----------------------------------------------------------------------------+
// | Module : hilbert_coef_rom                                                  |
// | Combinational lookup: pair index j -> Hilbert coefficient H(2j+1).         |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module hilbert_coef_rom
    import hilbert_pkg::*;
#(
    parameter int TAPS   = 11,
    parameter int COEF_W = 12,
    parameter int IDX_W  = 2
) (
    input  logic        [IDX_W-1:0]  idx,
    output logic signed [COEF_W-1:0] coef
);

    localparam int c_pairs = hilbert_pairs(TAPS);

    logic signed [COEF_W-1:0] w_tab [c_pairs];

    generate
        if (TAPS == REF_TAPS && COEF_W == REF_COEF_W) begin : g_ref
            for (genvar j = 0; j < c_pairs; j++) begin : g_entry
                assign w_tab[j] = REF_COEF[j];
            end
        end else begin : g_calc
            for (genvar j = 0; j < c_pairs; j++) begin : g_entry
                assign w_tab[j] = COEF_W'(hilbert_coef(2 * j + 1, COEF_W));
            end
        end
    endgenerate

    always_comb begin
        coef = '0;
        for (int j = 0; j < c_pairs; j++) begin
            if (idx == IDX_W'(j)) begin
                coef = w_tab[j];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/hilbert_fir_tdm.sv
// +----------------------------------------------------------------------------+
// | Module : hilbert_fir_tdm                                                   |
// | Analytic-signal generator: Re = centre tap, Im = Hilbert FIR using one    |
// | shared multiplier over the odd antisymmetric tap pairs.                   |
// | Optional macro HILBERT_SAT_EN: saturate Im instead of wrapping.           |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module hilbert_fir_tdm
    import hilbert_pkg::*;
#(
    parameter int DATA_W = 12,
    parameter int TAPS   = 11,
    parameter int COEF_W = 12,
    parameter int ACC_W  = DATA_W + COEF_W + 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic signed [DATA_W-1:0] IN,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic signed [DATA_W-1:0] Re,
    output logic signed [DATA_W-1:0] Im,
    output logic                     out_valid
);

    localparam int c_centre = hilbert_centre(TAPS);
    localparam int c_pairs  = hilbert_pairs(TAPS);
    localparam int c_cnt_w  = (c_pairs > 1) ? clog2(c_pairs) : 1;
    localparam logic        [c_cnt_w-1:0] c_last = c_cnt_w'(c_pairs - 1);
    localparam logic signed [ACC_W-1:0]   c_half = ACC_W'(2 ** (COEF_W - 2));

    logic signed [DATA_W-1:0] r_dly [TAPS];
    state_t                   r_state;
    logic        [c_cnt_w-1:0] r_cnt;
    logic signed [ACC_W-1:0]  r_acc;
    logic signed [DATA_W-1:0] r_re;
    logic signed [DATA_W-1:0] r_im;
    logic                     r_in_ready;
    logic                     r_out_valid;

    logic signed [DATA_W-1:0] w_near [c_pairs];
    logic signed [DATA_W-1:0] w_far  [c_pairs];
    logic signed [DATA_W-1:0] w_sel_near;
    logic signed [DATA_W-1:0] w_sel_far;
    logic signed [DATA_W:0]   w_diff;
    logic signed [COEF_W-1:0] w_coef;
    logic signed [ACC_W-1:0]  w_prod;
    logic signed [DATA_W-1:0] w_im_next;

    // Pair j combines the taps at distance k = 2j+1 either side of the centre
    generate
        for (genvar j = 0; j < c_pairs; j++) begin : g_pair
            assign w_near[j] = r_dly[c_centre - 2 * j - 1];
            assign w_far[j]  = r_dly[c_centre + 2 * j + 1];
        end
    endgenerate

    always_comb begin
        w_sel_near = '0;
        w_sel_far  = '0;
        for (int j = 0; j < c_pairs; j++) begin
            if (r_cnt == c_cnt_w'(j)) begin
                w_sel_near = w_near[j];
                w_sel_far  = w_far[j];
            end
        end
    end

    hilbert_coef_rom #(
        .TAPS   (TAPS),
        .COEF_W (COEF_W),
        .IDX_W  (c_cnt_w)
    ) u_coef_rom (
        .idx  (r_cnt),
        .coef (w_coef)
    );

    assign w_diff = (DATA_W+1)'(w_sel_near) - (DATA_W+1)'(w_sel_far);
    assign w_prod = ACC_W'(w_diff) * ACC_W'(w_coef);

`ifdef HILBERT_SAT_EN
    localparam logic signed [ACC_W-1:0] c_max = ACC_W'(2 ** (DATA_W - 1) - 1);
    localparam logic signed [ACC_W-1:0] c_min = -c_max - 1;

    logic signed [ACC_W-1:0] w_scaled;

    assign w_scaled = (r_acc + c_half) >>> (COEF_W - 1);

    always_comb begin
        if (w_scaled > c_max) begin
            w_im_next = {1'b0, {(DATA_W-1){1'b1}}};
        end else if (w_scaled < c_min) begin
            w_im_next = {1'b1, {(DATA_W-1){1'b0}}};
        end else begin
            w_im_next = w_scaled[DATA_W-1:0];
        end
    end
`else
    assign w_im_next = DATA_W'((r_acc + c_half) >>> (COEF_W - 1));
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < TAPS; i++) begin
                r_dly[i] <= '0;
            end
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_re        <= '0;
            r_im        <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_dly[0] <= IN;
                        for (int i = 1; i < TAPS; i++) begin
                            r_dly[i] <= r_dly[i-1];
                        end
                        r_acc      <= '0;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    r_acc <= r_acc + w_prod;
                    if (r_cnt == c_last) begin
                        r_state <= ST_OUT;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_w'(1);
                    end
                end
                ST_OUT: begin
                    // Ready re-opens together with the strobe so the next
                    // sample can be taken on the following edge
                    r_re        <= r_dly[c_centre];
                    r_im        <= w_im_next;
                    r_out_valid <= 1'b1;
                    r_in_ready  <= 1'b1;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign Re        = r_re;
    assign Im        = r_im;
    assign out_valid = r_out_valid;

endmodule

`default_nettype wire

// File: tb/tb_hilbert_fir_tdm.sv
// +----------------------------------------------------------------------------+
// | Module : tb_hilbert_fir_tdm                                                |
// | Scoreboard bench for hilbert_fir_tdm with an arithmetic reference model.  |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_hilbert_fir_tdm;

    localparam int DATA_W = 12;
    localparam int TAPS   = 11;
    localparam int CENTRE = 5;
    localparam int LAT    = 4;
    localparam int HK     [3]  = '{1304, 435, 261};
    localparam int IMP_IM [11] = '{131, 0, 218, 0, 652, 0, -652, 0, -217, 0, -130};
`ifdef HILBERT_SAT_EN
    localparam int SAT_IM = 2047;
`else
    localparam int SAT_IM = -97;
`endif

    typedef struct {
        int cyc;
        int re;
        int im;
    } exp_t;

    logic                     clock;
    logic                     reset;
    logic                     in_valid;
    logic                     in_ready;
    logic                     out_valid;
    logic signed [DATA_W-1:0] IN;
    logic signed [DATA_W-1:0] Re;
    logic signed [DATA_W-1:0] Im;

    exp_t sbq [$];
    exp_t mon_e;
    int   hist [$];
    int   log_re [$];
    int   log_im [$];
    int   cyc = 0;
    int   last_acc = -1000;
    int   last_re = 0;
    int   last_im = 0;
    int   total = 0;
    int   bad = 0;
    int   n_acc = 0;
    int   n_out = 0;

    hilbert_fir_tdm dut (
        .clock     (clock),
        .reset     (reset),
        .IN        (IN),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Re        (Re),
        .Im        (Im),
        .out_valid (out_valid)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int sample_at(input int j);
        return (j < hist.size()) ? hist[j] : 0;
    endfunction

    // Im = round_half_up(sum H(k)*(x[C-k]-x[C+k]) / 2^11), then saturate or wrap
    function automatic int ref_im();
        longint acc;
        longint r;
        acc = 0;
        for (int i = 0; i < 3; i++) begin
            acc += longint'(HK[i]) * longint'(sample_at(CENTRE - (2*i+1)) - sample_at(CENTRE + (2*i+1)));
        end
        r = (acc + 1024) >>> 11;
`ifdef HILBERT_SAT_EN
        if (r > 2047) r = 2047;
        else if (r < -2048) r = -2048;
`else
        r = ((r + 2048) % 4096 + 4096) % 4096 - 2048;
`endif
        return int'(r);
    endfunction

    function automatic bit model_ready();
        return (cyc - last_acc) >= LAT;
    endfunction

    task automatic model_reset();
        sbq.delete();
        hist.delete();
        last_acc = -1000;
        last_re  = 0;
        last_im  = 0;
    endtask

    task automatic drive(input logic v, input int x, output logic acc);
        exp_t e;
        @(negedge clock);
        #1;
        in_valid = v;
        IN       = DATA_W'(x);
        acc      = v && reset && model_ready();
        if (acc) begin
            hist.push_front(x);
            if (hist.size() > TAPS) void'(hist.pop_back());
            e.cyc = cyc + 1 + LAT;
            e.re  = sample_at(CENTRE);
            e.im  = ref_im();
            sbq.push_back(e);
            last_acc = cyc + 1;
            n_acc++;
        end
    endtask

    task automatic send(input int x);
        logic a;
        a = 1'b0;
        for (int i = 0; i < 20 && !a; i++) drive(1'b1, x, a);
        chk("send_accepted", int'(a), 1);
    endtask

    task automatic idle(input int n);
        logic a;
        for (int i = 0; i < n; i++) drive(1'b0, 0, a);
    endtask

    task automatic impulse_run();
        log_re.delete();
        log_im.delete();
        send(1024);
        for (int i = 0; i < 10; i++) send(0);
        idle(6);
        chk("impulse_count", log_im.size(), 11);
        for (int n = 0; n < 11 && n < log_im.size(); n++) begin
            chk($sformatf("impulse_im[%0d]", n), log_im[n], IMP_IM[n]);
            chk($sformatf("impulse_re[%0d]", n), log_re[n], (n == 5) ? 1024 : 0);
        end
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            chk("rst_in_ready", int'(in_ready), 1);
            chk("rst_out_valid", int'(out_valid), 0);
            chk("rst_re", int'(Re), 0);
            chk("rst_im", int'(Im), 0);
        end else begin
            chk("in_ready", int'(in_ready), int'(model_ready()));
            if (out_valid) begin
                n_out++;
                chk("out_expected", int'(sbq.size() > 0), 1);
                if (sbq.size() > 0) begin
                    mon_e = sbq.pop_front();
                    chk("out_cycle", cyc, mon_e.cyc);
                    chk("out_re", int'(Re), mon_e.re);
                    chk("out_im", int'(Im), mon_e.im);
                    last_re = mon_e.re;
                    last_im = mon_e.im;
                end
                log_re.push_back(int'(Re));
                log_im.push_back(int'(Im));
            end else begin
                chk("hold_re", int'(Re), last_re);
                chk("hold_im", int'(Im), last_im);
                chk("no_missing_out", int'(sbq.size() > 0 && sbq[0].cyc < cyc), 0);
                if (sbq.size() > 0 && sbq[0].cyc < cyc) void'(sbq.pop_front());
            end
        end
    end

    initial begin
        logic a;
        int   o0;
        int   a0;
        reset    = 1'b0;
        in_valid = 1'b0;
        IN       = '0;
        model_reset();

        // Offer samples while reset is held: nothing may be captured
        for (int i = 0; i < 4; i++) drive(1'b1, 100 + i, a);
        @(negedge clock);
        #1;
        reset    = 1'b1;
        in_valid = 1'b0;

        impulse_run();

        log_re.delete();
        log_im.delete();
        for (int i = 0; i < 15; i++) send(2047);
        idle(6);
        chk("dc_count", log_im.size(), 15);
        if (log_im.size() > 0) begin
            chk("dc_re", log_re[$], 2047);
            chk("dc_im", log_im[$], 0);
        end

        log_re.delete();
        log_im.delete();
        for (int i = 0; i < 6; i++) send(-2048);
        for (int i = 0; i < 5; i++) send(2047);
        idle(6);
        chk("sat_count", log_im.size(), 11);
        if (log_im.size() > 0) begin
            chk("sat_im", log_im[$], SAT_IM);
            chk("sat_re", log_re[$], -2048);
        end

        o0 = n_out;
        a0 = n_acc;
        for (int i = 0; i < 60; i++) drive(1'b1, int'($urandom_range(4095)) - 2048, a);
        idle(6);
        chk("flow_out_count", n_out - o0, n_acc - a0);
        chk("flow_accepts", int'(n_acc - a0 >= 11), 1);

        for (int i = 0; i < 300; i++) drive(1'($urandom_range(1)), int'($urandom_range(4095)) - 2048, a);
        idle(6);

        // Abort a sample mid-MAC; the following impulse must start from a clean line
        send(777);
        idle(2);
        reset = 1'b0;
        model_reset();
        idle(2);
        reset = 1'b1;
        impulse_run();

        idle(8);
        chk("scoreboard_empty", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
